// File: rtl/rcpu_mem_responder.sv
// rcpu_mem_responder: posted-write buffer and req/ack bridge between the rcpu memory port and external memory.
// Define RCPU_MEMRESP_FWD_EN to let reads hit buffered or incoming writes without draining the buffer.
module rcpu_mem_responder #(
  parameter int N = 32,
  parameter int M = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] memAddr,
  input  logic [M-1:0] memWrite,
  input  logic         memRE,
  input  logic         memWE,
  output logic [M-1:0] memRead,
  output logic         memReady,
  output logic         ext_req,
  output logic         ext_we,
  output logic [N-1:0] ext_addr,
  output logic [M-1:0] ext_wdata,
  input  logic         ext_ack,
  input  logic [M-1:0] ext_rdata,
  output logic         wbuf_empty,
  output logic         wr_overflow
);
  localparam int AW = $clog2(WBUF_DEPTH);
  typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;
  state_t state, state_nx;
  logic [N-1:0] fa [WBUF_DEPTH];
  logic [M-1:0] fd [WBUF_DEPTH];
  logic [AW-1:0] rp, wp;
  logic [AW:0] cnt;
  logic full, push, pop, hit;
  logic [M-1:0] fwd;
  assign full = cnt == (AW+1)'(WBUF_DEPTH);
  assign pop = state == WR && ext_ack;
  assign push = memWE && (!full || pop);
  assign ext_req = state == WR || state == RD;
  assign ext_we = state == WR;
  assign memReady = state == DONE;
  assign wbuf_empty = cnt == '0 && state != WR;
`ifdef RCPU_MEMRESP_FWD_EN
  // Oldest to newest, so the last match wins; the incoming write shares memAddr and is newest.
  always_comb begin
    hit = 1'b0;
    fwd = '0;
    for (int i = 0; i < WBUF_DEPTH; i++)
      if ((AW+1)'(i) < cnt && fa[rp + AW'(i)] == memAddr) begin
        hit = 1'b1;
        fwd = fd[rp + AW'(i)];
      end
    if (memWE) begin
      hit = 1'b1;
      fwd = memWrite;
    end
  end
`else
  assign hit = 1'b0;
  assign fwd = '0;
`endif
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = memRE && hit ? DONE : (cnt != '0 || memWE) ? WR : memRE ? RD : IDLE;
      WR:   state_nx = ext_ack ? IDLE : WR;
      RD:   state_nx = ext_ack ? DONE : RD;
      DONE: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (push) begin
      fa[wp] <= memAddr;
      fd[wp] <= memWrite;
    end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rp <= '0;
      wp <= '0;
      cnt <= '0;
      wr_overflow <= 1'b0;
      memRead <= '0;
      ext_addr <= '0;
      ext_wdata <= '0;
    end else begin
      state <= state_nx;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
      if (memWE && full && !pop) wr_overflow <= 1'b1;
      // An empty buffer means the write being pushed this cycle is the one to issue.
      if (state == IDLE && state_nx == WR) begin
        ext_addr <= cnt == '0 ? memAddr : fa[rp];
        ext_wdata <= cnt == '0 ? memWrite : fd[rp];
      end
      if (state == IDLE && state_nx == RD) ext_addr <= memAddr;
      if (state == RD && ext_ack) memRead <= ext_rdata;
      if (state == IDLE && state_nx == DONE) memRead <= fwd;
    end
  end
endmodule

// File: tb/tb_rcpu_mem_responder.sv
// tb_rcpu_mem_responder: table-driven reads plus directed ordering, overflow, forwarding and reset sequences.
module tb_rcpu_mem_responder;
  logic clk = 0, rst = 1;
  logic [31:0] memAddr = 0;
  logic [15:0] memWrite = 0, memRead, ext_wdata, ext_rdata = 0;
  logic memRE = 0, memWE = 0, memReady, ext_req, ext_we, ext_ack = 0, wbuf_empty, wr_overflow;
  logic [31:0] ext_addr;
  int checks = 0, failures = 0;
  int ack_dly = 0, wait_cnt = 0;
  logic stall = 0, force_ack = 0;
  logic [15:0] mem [logic [31:0]];
  typedef struct {logic we; logic [31:0] a; logic [15:0] d;} txn_t;
  txn_t log_q[$];
  typedef struct {logic [31:0] a; logic [15:0] d; int dly; int lat;} vec_t;
  vec_t vecs[4];

  rcpu_mem_responder dut (
    .clk(clk), .rst(rst), .memAddr(memAddr), .memWrite(memWrite), .memRE(memRE), .memWE(memWE),
    .memRead(memRead), .memReady(memReady), .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
    .ext_wdata(ext_wdata), .ext_ack(ext_ack), .ext_rdata(ext_rdata), .wbuf_empty(wbuf_empty),
    .wr_overflow(wr_overflow)
  );

  always #5 clk = ~clk;

  // External memory model: acks a request after ack_dly extra cycles, logging every transaction.
  always @(negedge clk) begin
    ext_ack = force_ack;
    if (ext_req && !rst && !stall) begin
      if (wait_cnt == ack_dly) begin
        ext_ack = 1;
        wait_cnt = 0;
        if (ext_we) mem[ext_addr] = ext_wdata;
        else ext_rdata = mem.exists(ext_addr) ? mem[ext_addr] : 16'hDEAD;
        log_q.push_back('{ext_we, ext_addr, ext_we ? ext_wdata : ext_rdata});
      end else wait_cnt++;
    end else wait_cnt = 0;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic write1(input logic [31:0] a, input logic [15:0] d);
    memAddr = a;
    memWrite = d;
    memWE = 1;
    tick;
    memWE = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output logic req1, output logic we1);
    memAddr = a;
    memRE = 1;
    tick;
    lat = 1;
    req1 = ext_req;
    we1 = ext_we;
    while (!memReady && lat < 60) begin
      tick;
      lat++;
    end
    memRE = 0;
  endtask

  task automatic wait_empty;
    for (int i = 0; i < 60 && !wbuf_empty; i++) tick;
    chk("drain_timeout", wbuf_empty, 1);
  endtask

  initial begin
    int lat, n0;
    logic r1, w1;
    vecs[0] = '{32'h0000_1234, 16'hBEEF, 0, 2};
    vecs[1] = '{32'hFFFF_FFFF, 16'h0001, 1, 3};
    vecs[2] = '{32'h0000_0000, 16'hFFFF, 2, 4};
    vecs[3] = '{32'h0000_0010, 16'h5A5A, 3, 5};
    tick;
    tick;
    rst = 0;
    chk("rst_memReady", memReady, 0);
    chk("rst_memRead", memRead, 0);
    chk("rst_ext_req", ext_req, 0);
    chk("rst_ext_we", ext_we, 0);
    chk("rst_ext_addr", ext_addr, 0);
    chk("rst_ext_wdata", ext_wdata, 0);
    chk("rst_wbuf_empty", wbuf_empty, 1);
    chk("rst_wr_overflow", wr_overflow, 0);

    foreach (vecs[k]) begin
      mem[vecs[k].a] = vecs[k].d;
      ack_dly = vecs[k].dly;
      do_read(vecs[k].a, lat, r1, w1);
      chk($sformatf("rd%0d_req_t1", k), r1, 1);
      chk($sformatf("rd%0d_we_t1", k), w1, 0);
      chk($sformatf("rd%0d_latency", k), lat, vecs[k].lat);
      chk($sformatf("rd%0d_ready", k), memReady, 1);
      chk($sformatf("rd%0d_data", k), memRead, vecs[k].d);
      tick;
      chk($sformatf("rd%0d_ready_pulse", k), memReady, 0);
      chk($sformatf("rd%0d_data_hold", k), memRead, vecs[k].d);
    end

    ack_dly = 3;
    n0 = log_q.size();
    write1(32'h10, 16'h1111);
    chk("ord_wbuf_busy", wbuf_empty, 0);
    do_read(32'h10, lat, r1, w1);
    chk("ord_latency", lat, 9);
    chk("ord_data", memRead, 16'h1111);
    chk("ord_log_size", log_q.size() - n0, 2);
    chk("ord_first_we", log_q[n0].we, 1);
    chk("ord_first_data", log_q[n0].d, 16'h1111);
    chk("ord_second_we", log_q[n0+1].we, 0);
    chk("ord_second_addr", log_q[n0+1].a, 32'h10);
    tick;

    stall = 1;
    n0 = log_q.size();
    for (int i = 0; i < 5; i++) write1(32'h100 + i, 16'hA000 + 16'(i));
    chk("ovf_flag", wr_overflow, 1);
    stall = 0;
    ack_dly = 0;
    wait_empty;
    chk("ovf_log_size", log_q.size() - n0, 4);
    for (int i = 0; i < 4 && n0 + i < log_q.size(); i++) begin
      chk($sformatf("ovf_addr%0d", i), log_q[n0+i].a, 32'h100 + i);
      chk($sformatf("ovf_data%0d", i), log_q[n0+i].d, 16'hA000 + 16'(i));
    end
    chk("ovf_fifth_dropped", mem.exists(32'h104), 0);
    tick;
    chk("ovf_sticky", wr_overflow, 1);

    stall = 1;
    n0 = log_q.size();
    write1(32'h20, 16'hAAAA);
    write1(32'h20, 16'hBBBB);
    memAddr = 32'h20;
    memRE = 1;
    tick;
    tick;
    stall = 0;
    for (int i = 0; i < 60 && !memReady; i++) tick;
    memRE = 0;
    chk("fwd_ready", memReady, 1);
    chk("fwd_data", memRead, 16'hBBBB);
    wait_empty;
    tick;
    tick;
    chk("fwd_wr0", log_q[n0].d, 16'hAAAA);
    chk("fwd_wr1", log_q[n0+1].d, 16'hBBBB);
`ifdef RCPU_MEMRESP_FWD_EN
    chk("fwd_no_rd", log_q.size() - n0, 2);
`else
    chk("fwd_rd_after_wr", log_q.size() - n0, 3);
    chk("fwd_rd_we", log_q[n0+2].we, 0);
`endif

    stall = 1;
    write1(32'h30, 16'h3333);
    chk("mid_ext_req", ext_req, 1);
    chk("mid_ext_we", ext_we, 1);
    chk("mid_ext_addr", ext_addr, 32'h30);
    chk("mid_ext_wdata", ext_wdata, 16'h3333);
    rst = 1;
    tick;
    chk("mid_req_drop", ext_req, 0);
    tick;
    rst = 0;
    chk("mid_wbuf_empty", wbuf_empty, 1);
    chk("mid_memReady", memReady, 0);
    chk("mid_overflow_clr", wr_overflow, 0);
    chk("mid_ext_addr_rst", ext_addr, 0);
    stall = 0;
    n0 = log_q.size();
    force_ack = 1;
    tick;
    force_ack = 0;
    tick;
    chk("stray_ext_req", ext_req, 0);
    chk("stray_wbuf_empty", wbuf_empty, 1);
    chk("stray_memReady", memReady, 0);
    chk("stray_memRead", memRead, 0);
    chk("stray_no_txn", log_q.size() - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
